// File: rtl/vend_pkg.sv
// Shared constants for the vending coin path: payout FSM encoding, coin values
// and default amount/inventory widths.
package vend_pkg;

  localparam int unsigned DEF_AMT_W = 4;
  localparam int unsigned DEF_INV_W = 6;

  localparam int unsigned COIN1_VAL = 1;
  localparam int unsigned COIN2_VAL = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter shared by the eject pulse width and the coin-sense
// timeout window; expired goes high once the loaded count has run to zero.
module payout_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (start) begin
      cnt_n = load;
    end else if (cnt != '0) begin
      cnt_n = cnt - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      expired <= (cnt_n == '0);
    end
  end

endmodule

// File: rtl/change_payout.sv
// Greedy coin-return controller: pays unit-2 coins first and confirms each coin
// on coin_sense. Optional CHANGE_RETRY_EN re-ejects a coin once after its first timeout.
module change_payout
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W       = DEF_AMT_W,
  parameter int unsigned INV_W       = DEF_INV_W,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv1_in,
  input  logic [INV_W-1:0] inv2_in,
  output logic [INV_W-1:0] inv1_cnt,
  output logic [INV_W-1:0] inv2_cnt,
  output logic             eject_1,
  output logic             eject_2,
  input  logic             coin_sense,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  localparam int unsigned TMR_MAX = (PULSE_LEN > TIMEOUT_CYC) ? PULSE_LEN : TIMEOUT_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic             coin2;
  logic             coin2_n;
  logic             pend;
  logic             pend_n;
  logic             short_n;
  logic [AMT_W-1:0] rem_n;
  logic [INV_W-1:0] inv1_n;
  logic [INV_W-1:0] inv2_n;
  logic [AMT_W-1:0] coin_val;
  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_expired;
`ifdef CHANGE_RETRY_EN
  logic             retry;
  logic             retry_n;
`endif

  payout_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (tmr_start),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  assign coin_val = coin2 ? AMT_W'(COIN2_VAL) : AMT_W'(COIN1_VAL);

  // Next-state and datapath updates
  always_comb begin
    state_n   = state;
    coin2_n   = coin2;
    pend_n    = pend;
    short_n   = 1'b0;
    rem_n     = remaining;
    inv1_n    = inv1_cnt;
    inv2_n    = inv2_cnt;
    tmr_start = 1'b0;
    tmr_load  = '0;
`ifdef CHANGE_RETRY_EN
    retry_n   = retry;
`endif
    case (state)
      ST_IDLE: begin
        if (inv_load) begin
          inv1_n = inv1_in;
          inv2_n = inv2_in;
        end else if (req_valid) begin
          rem_n   = req_amount;
          state_n = ST_SELECT;
        end
      end
      ST_SELECT: begin
        pend_n = 1'b0;
        if (remaining == '0) begin
          state_n = ST_DONE;
        end else if (remaining >= AMT_W'(COIN2_VAL) && inv2_cnt != '0) begin
          coin2_n   = 1'b1;
          state_n   = ST_EJECT;
          tmr_start = 1'b1;
          tmr_load  = PULSE_LOAD;
        end else if (inv1_cnt != '0) begin
          coin2_n   = 1'b0;
          state_n   = ST_EJECT;
          tmr_start = 1'b1;
          tmr_load  = PULSE_LOAD;
        end else begin
          state_n = ST_DONE;
          short_n = 1'b1;
        end
      end
      ST_EJECT: begin
        // An early coin is remembered and credited on the first WAIT cycle.
        if (coin_sense) pend_n = 1'b1;
        if (tmr_expired) begin
          state_n   = ST_WAIT;
          tmr_start = 1'b1;
          tmr_load  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (coin_sense || pend) begin
          rem_n   = remaining - coin_val;
          pend_n  = 1'b0;
          state_n = ST_SELECT;
          if (coin2) inv2_n = inv2_cnt - INV_W'(1);
          else       inv1_n = inv1_cnt - INV_W'(1);
`ifdef CHANGE_RETRY_EN
          retry_n = 1'b0;
`endif
        end else if (tmr_expired) begin
`ifdef CHANGE_RETRY_EN
          if (!retry) begin
            retry_n   = 1'b1;
            state_n   = ST_EJECT;
            tmr_start = 1'b1;
            tmr_load  = PULSE_LOAD;
          end else begin
            state_n = ST_FAULT;
          end
`else
          state_n = ST_FAULT;
`endif
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_FAULT: state_n = ST_FAULT;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      coin2     <= 1'b0;
      pend      <= 1'b0;
      remaining <= '0;
      inv1_cnt  <= '0;
      inv2_cnt  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      fault     <= 1'b0;
      eject_1   <= 1'b0;
      eject_2   <= 1'b0;
    end else begin
      state     <= state_n;
      coin2     <= coin2_n;
      pend      <= pend_n;
      remaining <= rem_n;
      inv1_cnt  <= inv1_n;
      inv2_cnt  <= inv2_n;
      req_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE) && (state_n != ST_FAULT);
      done      <= (state_n == ST_DONE);
      short     <= short_n;
      fault     <= (state_n == ST_FAULT);
      eject_1   <= (state_n == ST_EJECT) && !coin2_n;
      eject_2   <= (state_n == ST_EJECT) && coin2_n;
    end
  end

`ifdef CHANGE_RETRY_EN
  always_ff @(posedge clk) begin
    if (!reset) retry <= 1'b0;
    else        retry <= retry_n;
  end
`endif

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: a transaction-level payout plan is expanded into a
// per-cycle table of inputs and expected outputs that drives and checks the DUT.
module tb_change_payout;

  localparam int unsigned AMT_W = 4;
  localparam int unsigned INV_W = 6;
  localparam int PULSE_LEN   = 4;
  localparam int TIMEOUT_CYC = 1000;
`ifdef CHANGE_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             inv_load;
  logic [INV_W-1:0] inv1_in;
  logic [INV_W-1:0] inv2_in;
  logic [INV_W-1:0] inv1_cnt;
  logic [INV_W-1:0] inv2_cnt;
  logic             eject_1;
  logic             eject_2;
  logic             coin_sense;
  logic             busy;
  logic             done;
  logic             short;
  logic             fault;
  logic [AMT_W-1:0] remaining;

  change_payout #(
    .AMT_W(AMT_W), .INV_W(INV_W), .PULSE_LEN(PULSE_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .inv_load(inv_load), .inv1_in(inv1_in), .inv2_in(inv2_in),
    .inv1_cnt(inv1_cnt), .inv2_cnt(inv2_cnt), .eject_1(eject_1), .eject_2(eject_2),
    .coin_sense(coin_sense), .busy(busy), .done(done), .short(short), .fault(fault),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rv, il, cs;
    logic [AMT_W-1:0] amt;
    logic [INV_W-1:0] i1, i2;
    bit   chk;
    int   mark;
    logic rdy, bsy, dn, sh, flt, e1, e2;
    logic [AMT_W-1:0] rem;
    logic [INV_W-1:0] n1, n2;
  } ent_t;

  ent_t q[$];
  ent_t st;
  ent_t cur;
  bit   cur_valid = 1'b0;
  logic [AMT_W-1:0] m_rem;
  logic [INV_W-1:0] m_inv1, m_inv2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---- plan builder: one emit() per clock cycle ----
  function automatic void outs(bit r, bit b, bit d, bit s, bit f, bit e1, bit e2);
    st.rdy = r; st.bsy = b; st.dn = d; st.sh = s; st.flt = f; st.e1 = e1; st.e2 = e2;
  endfunction

  function automatic void emit();
    st.rem = m_rem; st.n1 = m_inv1; st.n2 = m_inv2;
    q.push_back(st);
    st.rst = 1'b1; st.rv = 1'b0; st.il = 1'b0; st.cs = 1'b0;
    st.amt = '0; st.i1 = '0; st.i2 = '0; st.chk = 1'b1; st.mark = 0;
  endfunction

  function automatic void model_reset();
    m_rem = '0; m_inv1 = '0; m_inv2 = '0;
    outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void do_reset(int n, bit first_known);
    for (int i = 0; i < n; i++) begin
      st.rst = 1'b0;
      if (i == 0) st.chk = first_known;
      emit();
      model_reset();
    end
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) emit();
  endfunction

  function automatic void load(int a1, int a2);
    st.il = 1'b1; st.i1 = INV_W'(a1); st.i2 = INV_W'(a2);
    emit();
    m_inv1 = INV_W'(a1); m_inv2 = INV_W'(a2);
  endfunction

  // s: sense offset from first eject cycle (-1 never); abort_k: eject cycle with reset low
  function automatic void request(int a, int s, int abort_k, int dmark, int fmark);
    int  v;
    bit  sensed;
    outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    st.rv = 1'b1; st.amt = AMT_W'(a);
    emit();
    m_rem = AMT_W'(a);
    for (int g = 0; g < 32; g++) begin
      outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      emit();
      if (int'(m_rem) >= 2 && m_inv2 != 0) v = 2;
      else if (m_rem != 0 && m_inv1 != 0) v = 1;
      else v = 0;
      if (v == 0) begin
        outs(1'b0, 1'b1, 1'b1, m_rem != 0, 1'b0, 1'b0, 1'b0);
        st.mark = dmark;
        emit();
        outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      sensed = 1'b0;
      for (int att = 0; att < ATTEMPTS && !sensed; att++) begin
        for (int k = 0; k < PULSE_LEN; k++) begin
          outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v == 1, v == 2);
          st.cs = (s == k);
          if (k == abort_k) begin
            st.rst = 1'b0;
            emit();
            model_reset();
            st.mark = 5;
            return;
          end
          emit();
        end
        outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (s >= 0 && s < PULSE_LEN) begin
          emit();
          sensed = 1'b1;
        end else begin
          for (int k = PULSE_LEN; k < PULSE_LEN + TIMEOUT_CYC && !sensed; k++) begin
            st.cs = (s == k);
            sensed = (s == k);
            emit();
          end
        end
      end
      if (!sensed) begin
        outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        st.mark = fmark;
        emit();
        idle(3);
        return;
      end
      m_rem = m_rem - AMT_W'(v);
      if (v == 2) m_inv2 = m_inv2 - INV_W'(1);
      else        m_inv1 = m_inv1 - INV_W'(1);
    end
  endfunction

  task automatic play();
    ent_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      reset = e.rst; req_valid = e.rv; req_amount = e.amt; inv_load = e.il;
      inv1_in = e.i1; inv2_in = e.i2; coin_sense = e.cs;
      cur = e;
      cur_valid = 1'b1;
    end
  endtask

  // Per-cycle compare against the plan, plus literal pins at marked cycles
  always @(negedge clk) begin
    if (cur_valid && cur.chk) begin
      check("req_ready", 32'(req_ready), 32'(cur.rdy));
      check("busy", 32'(busy), 32'(cur.bsy));
      check("done", 32'(done), 32'(cur.dn));
      check("short", 32'(short), 32'(cur.sh));
      check("fault", 32'(fault), 32'(cur.flt));
      check("eject_1", 32'(eject_1), 32'(cur.e1));
      check("eject_2", 32'(eject_2), 32'(cur.e2));
      check("remaining", 32'(remaining), 32'(cur.rem));
      check("inv1_cnt", 32'(inv1_cnt), 32'(cur.n1));
      check("inv2_cnt", 32'(inv2_cnt), 32'(cur.n2));
      case (cur.mark)
        10: begin
          check("lit_reset_ready", 32'(req_ready), 32'd1);
          check("lit_reset_busy", 32'(busy), 32'd0);
          check("lit_reset_inv1", 32'(inv1_cnt), 32'd0);
          check("lit_reset_rem", 32'(remaining), 32'd0);
        end
        1: begin
          check("lit_t1_done", 32'(done), 32'd1);
          check("lit_t1_short", 32'(short), 32'd0);
          check("lit_t1_inv1", 32'(inv1_cnt), 32'd4);
          check("lit_t1_inv2", 32'(inv2_cnt), 32'd4);
          check("lit_t1_rem", 32'(remaining), 32'd0);
        end
        2: begin
          check("lit_t2_done", 32'(done), 32'd1);
          check("lit_t2_short", 32'(short), 32'd1);
          check("lit_t2_rem", 32'(remaining), 32'd2);
          check("lit_t2_inv1", 32'(inv1_cnt), 32'd0);
        end
        3: begin
          check("lit_t3_done", 32'(done), 32'd1);
          check("lit_t3_short", 32'(short), 32'd0);
        end
        4: begin
          check("lit_t4_fault", 32'(fault), 32'd1);
          check("lit_t4_ready", 32'(req_ready), 32'd0);
          check("lit_t4_eject2", 32'(eject_2), 32'd0);
        end
        5: begin
          check("lit_t5_eject2", 32'(eject_2), 32'd0);
          check("lit_t5_ready", 32'(req_ready), 32'd1);
          check("lit_t5_inv2", 32'(inv2_cnt), 32'd0);
          check("lit_t5_done", 32'(done), 32'd0);
        end
        6: begin
          check("lit_t6_ready", 32'(req_ready), 32'd1);
          check("lit_t6_busy", 32'(busy), 32'd0);
          check("lit_t6_inv1", 32'(inv1_cnt), 32'd7);
          check("lit_t6_inv2", 32'(inv2_cnt), 32'd9);
        end
        7: begin
          check("lit_t7_inv1", 32'(inv1_cnt), 32'd6);
          check("lit_t7_inv2", 32'(inv2_cnt), 32'd7);
          check("lit_t7_rem", 32'(remaining), 32'd0);
        end
        8: begin
          check("lit_t8_done", 32'(done), 32'd1);
          check("lit_t8_short", 32'(short), 32'd0);
          check("lit_t8_inv1", 32'(inv1_cnt), 32'd5);
        end
        default: ;
      endcase
    end
  end

  // Timeout-to-fault distance, measured on the DUT
  bit arm = 1'b0;
  bit ej2_prev = 1'b0;
  int t_ej = -1;
  int t_fault = -1;
  int ej2_rises = 0;

  always @(negedge clk) begin
    ej2_prev <= eject_2;
    if (arm && eject_2 && !ej2_prev) ej2_rises <= ej2_rises + 1;
    if (arm && eject_2 && t_ej < 0) t_ej <= cyc;
    if (arm && fault && t_fault < 0) t_fault <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d actual running expected finished", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_amount = '0; inv_load = 1'b0;
    inv1_in = '0; inv2_in = '0; coin_sense = 1'b0;
    st.rst = 1'b1; st.rv = 1'b0; st.il = 1'b0; st.cs = 1'b0; st.amt = '0;
    st.i1 = '0; st.i2 = '0; st.chk = 1'b1; st.mark = 0;
    model_reset();

    do_reset(2, 1'b0);
    st.mark = 10;
    load(5, 5);
    request(3, PULSE_LEN + 2, -1, 1, 0);
    idle(1);
    play();

    load(1, 0);
    request(3, 1, -1, 2, 0);
    idle(1);
    st.cs = 1'b1;
    idle(1);
    request(0, -1, -1, 3, 0);
    idle(1);
    load(0, 3);
    play();

    arm = 1'b1;
    request(2, -1, -1, 0, 4);
    play();
    @(negedge clk);
    arm = 1'b0;
    check("timeout_to_fault", 32'(t_fault - t_ej), 32'(ATTEMPTS * (PULSE_LEN + TIMEOUT_CYC)));
    check("eject2_pulses", 32'(ej2_rises), 32'(ATTEMPTS));

    do_reset(1, 1'b1);
    load(2, 2);
    request(2, -1, 1, 0, 0);
    idle(3);
    st.il = 1'b1; st.i1 = INV_W'(7); st.i2 = INV_W'(9);
    st.rv = 1'b1; st.amt = AMT_W'(5);
    emit();
    m_inv1 = INV_W'(7); m_inv2 = INV_W'(9);
    st.mark = 6;
    request(5, PULSE_LEN, -1, 7, 0);
    idle(1);
    request(1, PULSE_LEN + TIMEOUT_CYC - 1, -1, 8, 0);
    idle(2);
    play();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
